// File: rtl/complex_subtractor_pipe_32b.sv
// Two-stage pipelined complex subtractor R = A - B on {real[31:16], imag[15:0]} 16-bit lanes.
// Optional macro COMPLEX_SUB_SAT_EN: saturate each lane on signed overflow (flags stay raw).
module complex_subtractor_pipe_32b #(
  parameter int CNT_W = 16,
  parameter int SPLIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      A32,
  input  logic [31:0]      B32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      R32,
  output logic [1:0]       BOUT_32,
  output logic [1:0]       OVF_32,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);
  localparam int HI_W = 16 - SPLIT;

  // Handshake: a stage advances when it is empty or its consumer takes its
  // item this cycle; transfers happen on valid && ready at each boundary.
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [1:0][SPLIT-1:0] s1_lo;
  logic [1:0]            s1_c;
  logic [1:0][HI_W-1:0]  s1_a_hi;
  logic [1:0][HI_W-1:0]  s1_nb_hi;

  logic [1:0][SPLIT:0]   lo_sum;
  logic [1:0][HI_W:0]    hi_sum;
  logic [1:0][15:0]      diff;
  logic [31:0]           r_next;
  logic [1:0]            bout_next;
  logic [1:0]            ovf_next;

  // Stage 1: low SPLIT bits of a + ~b + 1 per lane, carry kept for stage 2.
  always_comb begin
    lo_sum = '0;
    for (int l = 0; l < 2; l++) begin
      lo_sum[l] = {1'b0, A32[16*l +: SPLIT]} + {1'b0, ~B32[16*l +: SPLIT]}
                + {{SPLIT{1'b0}}, 1'b1};
    end
  end

  // Stage 2: upper bits plus stage-1 carry; a[15]!=b[15] is a15 == ~b15.
  always_comb begin
    hi_sum    = '0;
    diff      = '0;
    r_next    = '0;
    bout_next = '0;
    ovf_next  = '0;
    for (int l = 0; l < 2; l++) begin
      hi_sum[l]    = {1'b0, s1_a_hi[l]} + {1'b0, s1_nb_hi[l]} + {{HI_W{1'b0}}, s1_c[l]};
      diff[l]      = {hi_sum[l][HI_W-1:0], s1_lo[l]};
      bout_next[l] = ~hi_sum[l][HI_W];
      ovf_next[l]  = (s1_a_hi[l][HI_W-1] == s1_nb_hi[l][HI_W-1])
                  && (diff[l][15] != s1_a_hi[l][HI_W-1]);
`ifdef COMPLEX_SUB_SAT_EN
      if (ovf_next[l])
        r_next[16*l +: 16] = s1_a_hi[l][HI_W-1] ? 16'h8000 : 16'h7FFF;
      else
        r_next[16*l +: 16] = diff[l];
`else
      r_next[16*l +: 16] = diff[l];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= '0;
      s1_a_hi  <= '0;
      s1_nb_hi <= '0;
      R32      <= '0;
      BOUT_32  <= '0;
      OVF_32   <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv && in_valid) begin
        for (int l = 0; l < 2; l++) begin
          s1_lo[l]    <= lo_sum[l][SPLIT-1:0];
          s1_c[l]     <= lo_sum[l][SPLIT];
          s1_a_hi[l]  <= A32[16*l+SPLIT +: HI_W];
          s1_nb_hi[l] <= ~B32[16*l+SPLIT +: HI_W];
        end
      end
      if (s2_adv && s1_valid) begin
        R32     <= r_next;
        BOUT_32 <= bout_next;
        OVF_32  <= ovf_next;
      end
    end
  end

  // Overflow event counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && (|OVF_32) && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_complex_subtractor_pipe_32b.sv
// Bench for complex_subtractor_pipe_32b: arithmetic reference model, scoreboard queue, per-cycle monitor.
module tb_complex_subtractor_pipe_32b;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      A32 = '0;
  logic [31:0]      B32 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      R32;
  logic [1:0]       BOUT_32;
  logic [1:0]       OVF_32;
  logic [CNT_W-1:0] ovf_cnt;
  logic             cnt_clr = 1'b0;

  complex_subtractor_pipe_32b #(.CNT_W(CNT_W), .SPLIT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A32(A32), .B32(B32),
    .out_valid(out_valid), .out_ready(out_ready),
    .R32(R32), .BOUT_32(BOUT_32), .OVF_32(OVF_32),
    .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction per lane; returns {R32, BOUT_32, OVF_32}.
  function automatic logic [35:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [1:0]  bo, ov;
    int ua, ub, sa, sb, sd;
    logic [15:0] la, lb, lr;
    for (int l = 0; l < 2; l++) begin
      la = a[16*l +: 16];
      lb = b[16*l +: 16];
      ua = int'(la);
      ub = int'(lb);
      sa = int'($signed(la));
      sb = int'($signed(lb));
      sd = sa - sb;
      bo[l] = (ua < ub);
      ov[l] = (sd > 32767) || (sd < -32768);
      lr = sd[15:0];
`ifdef COMPLEX_SUB_SAT_EN
      if (ov[l]) lr = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
      r[16*l +: 16] = lr;
    end
    return {r, bo, ov};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [35:0] exp_q[$];
  int          acc_q[$];
  logic [CNT_W-1:0] cnt_m = '0;
  bit          check_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [35:0] prev_out;
  int          n_acc = 0;
  int          n_out = 0;

  always @(negedge clk) begin
    logic [35:0] e;
    bit ov_x;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      exp_q.delete();
      acc_q.delete();
      cnt_m = '0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (out_ready || exp_q.size() < 2));
      chk("ovf_cnt", ovf_cnt, cnt_m);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {R32, BOUT_32, OVF_32}, prev_out);
      end
      ov_x = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("R32", R32, e[35:4]);
          chk("BOUT_32", BOUT_32, e[3:2]);
          chk("OVF_32", OVF_32, e[1:0]);
          if (out_ready) begin
            if (check_lat) chk("latency", cycle - acc_q[0], 2);
            ov_x = |e[1:0];
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            n_out++;
          end
        end
      end
      if (cnt_clr) cnt_m = '0;
      else if (ov_x && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(A32, B32));
        acc_q.push_back(cycle);
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {R32, BOUT_32, OVF_32};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int budget = 200;
    bit done = 1'b0;
    in_valid = 1'b1;
    A32 = a;
    B32 = b;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
      budget--;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [35:0] pin;
    // Pin the model against hand-computed results.
    pin = ref_sub(32'h0005_0003, 32'h0002_0007);
    chk("model_v1", pin, {32'h0003_FFFC, 2'b01, 2'b00});
    pin = ref_sub(32'h8000_7FFF, 32'h0001_FFFF);
`ifdef COMPLEX_SUB_SAT_EN
    chk("model_v2", pin, {32'h8000_7FFF, 2'b01, 2'b11});
`else
    chk("model_v2", pin, {32'h7FFF_8000, 2'b01, 2'b11});
`endif
    pin = ref_sub(32'h1234_ABCD, 32'h1234_ABCD);
    chk("model_eq", pin, {32'h0, 2'b00, 2'b00});
    pin = ref_sub(32'h0000_0000, 32'h0001_0001);
    chk("model_0m1", pin, {32'hFFFF_FFFF, 2'b11, 2'b00});

    // Reset state.
    tick(3);
    chk("reset_R32", R32, 0);
    chk("reset_BOUT", BOUT_32, 0);
    chk("reset_OVF", OVF_32, 0);
    rst = 1'b0;
    tick(1);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_cnt", ovf_cnt, 0);

    // Directed vectors and boundaries with latency checking.
    check_lat = 1'b1;
    send(32'h0005_0003, 32'h0002_0007);
    send(32'h8000_7FFF, 32'h0001_FFFF);
    send(32'hA5A5_0000, 32'hA5A5_0001);
    send(32'h8000_8000, 32'h0001_0001);
    drain();
    chk("cnt_after_ovf", ovf_cnt, 2);

    // Back-to-back random burst.
    for (int i = 0; i < 8; i++) send($urandom(), $urandom());
    drain();
    check_lat = 1'b0;

    // Stall: 4 vectors streaming, output held off for 5 cycles after the first result.
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom(), $urandom());
      end
      begin
        int budget = 50;
        while (!out_valid && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        if (!out_valid) chk("stall_first_out", 0, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready_low", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation, then clear colliding with an overflow transfer.
    for (int i = 0; i < 20; i++) send(32'h8000_8000, 32'h0001_0001);
    drain();
    chk("cnt_saturated", ovf_cnt, 15);
    send(32'h7FFF_0000, 32'hFFFF_0000);
    cnt_clr = 1'b1;
    tick(2);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_priority", ovf_cnt, 0);
    drain();

    // Random traffic with backpressure and occasional clears.
    begin
      bit acc;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 3))
            0: begin A32 = $urandom(); B32 = A32; end
            1: begin A32 = {1'b1, 15'($urandom()), 1'b0, 15'($urandom())};
                     B32 = {1'b0, 15'($urandom()), 1'b1, 15'($urandom())}; end
            default: begin A32 = $urandom(); B32 = $urandom(); end
          endcase
        end
        out_ready = ($urandom_range(0, 2) != 0);
        cnt_clr = ($urandom_range(0, 63) == 0);
      end
      in_valid = 1'b0;
      cnt_clr = 1'b0;
      out_ready = 1'b1;
      drain();
    end

    // Reset with two items in flight.
    send($urandom(), $urandom());
    send(32'h8000_0000, 32'h0001_0000);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_cnt", ovf_cnt, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    chk("all_results_out", n_out, n_acc - 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
